// File: rtl/pixel_writeback_master_pkg.sv
// Shared definitions for the pixel write-back master: FSM state encoding
// and a helper that turns a raster coordinate into a byte offset.
package pixel_writeback_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte offset of pixel (x, y) in a row-major frame.
    // The result wraps modulo 2^32, and the caller truncates it to ADDR_W bits.
    function automatic logic [31:0] pix_offset(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] width,
        input logic [31:0] bytes_per_pix
    );
        return (y * width + x) * bytes_per_pix;
    endfunction

endpackage

// File: rtl/pixel_writeback_master_raster_counter.sv
// Raster-order X/Y coordinate counter. It steps once per increment and saturates
// at the last pixel of the frame until it is cleared.
module raster_counter #(
    parameter int IMG_W = 4,
    parameter int IMG_H = 3,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          inc_i,
    input  logic          clear_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          at_row_end;

    assign at_row_end = (x_q == X_MAX);
    assign last_o     = at_row_end && (y_q == Y_MAX);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (inc_i && !last_o) begin
            if (at_row_end) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/pixel_writeback_master.sv
// Streams one frame of pixels into memory through an Avalon-MM write master.
// Pixels are written in raster order starting at a base address.
module pixel_writeback_master
    import pixel_writeback_master_pkg::*;
#(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 3,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          base_addr_i,
    input  logic                       pix_valid_i,
    input  logic [DATA_W-1:0]          pix_data_i,
    output logic                       pix_ready_o,
    output logic [ADDR_W-1:0]          avm_address_o,
    output logic                       avm_write_o,
    output logic [DATA_W-1:0]          avm_writedata_o,
    input  logic                       avm_waitrequest_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(IMG_W)-1:0]   X_o,
    output logic [$clog2(IMG_H)-1:0]   Y_o
);

    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int BPP = DATA_W / 8;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_q, wr_d;
    logic                all_acc_q, all_acc_d;

    logic                cnt_clear;
    logic                accept;
    logic                slot_free;
    logic                last_pix;
    logic [XW-1:0]       x_cur;
    logic [YW-1:0]       y_cur;
    logic [ADDR_W-1:0]   pix_addr;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW)
    ) u_raster (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (accept),
        .clear_i (cnt_clear),
        .x_o     (x_cur),
        .y_o     (y_cur),
        .last_o  (last_pix)
    );

    // The output register can take a new pixel when it is empty or draining this cycle.
    assign slot_free   = !wr_q || !avm_waitrequest_i;
    assign pix_ready_o = (state_q == RUN) && !all_acc_q && slot_free;
    assign accept      = pix_valid_i && pix_ready_o;
    assign pix_addr    = base_q + ADDR_W'(pix_offset(32'(x_cur), 32'(y_cur),
                                                     32'(IMG_W), 32'(BPP)));

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = wr_q;
        all_acc_d = all_acc_q;
        cnt_clear = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = RUN;
                    base_d    = base_addr_i;
                    all_acc_d = 1'b0;
                    cnt_clear = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    wr_d   = 1'b1;
                    addr_d = pix_addr;
                    data_d = pix_data_i;
                    if (last_pix) begin
                        all_acc_d = 1'b1;
                    end
                end else if (wr_q && !avm_waitrequest_i) begin
                    wr_d = 1'b0;
                end
                // Leave only once the final write has actually been taken by the slave.
                if (all_acc_q && slot_free) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            all_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            all_acc_q <= all_acc_d;
        end
    end

    assign avm_address_o   = addr_q;
    assign avm_writedata_o = data_q;
    assign avm_write_o     = wr_q;
    assign busy_o          = (state_q == RUN);
    assign done_o          = (state_q == DONE);
    assign X_o             = x_cur;
    assign Y_o             = y_cur;

endmodule

// File: tb/tb_pixel_writeback_master.sv
// Directed bench for pixel_writeback_master (4x3 frame, 8-bit pixels, 32-bit addresses).
module tb_pixel_writeback_master;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic        pix_valid_i;
    logic [7:0]  pix_data_i;
    logic        pix_ready_o;
    logic [31:0] avm_address_o;
    logic        avm_write_o;
    logic [7:0]  avm_writedata_o;
    logic        avm_waitrequest_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  X_o;
    logic [1:0]  Y_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] pix_cnt;

    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    int          wr_cyc[$];
    logic [1:0]  acc_x[$];
    logic [1:0]  acc_y[$];

    always #5 clk = ~clk;

    pixel_writeback_master #(
        .IMG_W (4),
        .IMG_H (3),
        .DATA_W(8),
        .ADDR_W(32)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .start_i          (start_i),
        .base_addr_i      (base_addr_i),
        .pix_valid_i      (pix_valid_i),
        .pix_data_i       (pix_data_i),
        .pix_ready_o      (pix_ready_o),
        .avm_address_o    (avm_address_o),
        .avm_write_o      (avm_write_o),
        .avm_writedata_o  (avm_writedata_o),
        .avm_waitrequest_i(avm_waitrequest_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .X_o              (X_o),
        .Y_o              (Y_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log acceptances and completed writes before the edge, advance the pixel source after it.
    task automatic tick();
        logic acc;
        @(negedge clk);
        acc = pix_valid_i && pix_ready_o;
        if (acc) begin
            acc_x.push_back(X_o);
            acc_y.push_back(Y_o);
        end
        if (avm_write_o && !avm_waitrequest_i) begin
            wr_addr.push_back(avm_address_o);
            wr_data.push_back(avm_writedata_o);
            wr_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (acc) begin
            pix_cnt    = pix_cnt + 8'd1;
            pix_data_i = 8'h40 + pix_cnt;
        end
    endtask

    task automatic start_frame(input logic [31:0] b);
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc_x.delete();
        acc_y.delete();
        pix_cnt     = 8'd0;
        pix_data_i  = 8'h40;
        base_addr_i = b;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        for (int i = 0; i < 100 && !done_o; i++) tick();
        check(tag, done_o, 1'b1);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] b);
        check({tag, "_count"}, wr_addr.size(), 12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], b + 32'(i));
            check($sformatf("%s_data%0d", tag, i), wr_data[i], 8'h40 + 8'(i));
        end
    endtask

    initial begin
        rst_n_i           = 1'b0;
        start_i           = 1'b0;
        base_addr_i       = 32'h0;
        pix_valid_i       = 1'b1;
        pix_data_i        = 8'h40;
        pix_cnt           = 8'd0;
        avm_waitrequest_i = 1'b0;
        tick();
        tick();
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_write", avm_write_o, 1'b0);
        check("rst_addr", avm_address_o, 32'h0);
        check("rst_data", avm_writedata_o, 8'h0);
        check("rst_x", X_o, 2'd0);
        check("rst_y", Y_o, 2'd0);
        rst_n_i = 1'b1;
        tick();
        check("idle_ready", pix_ready_o, 1'b0);

        // Back-to-back frame with no stalls.
        start_frame(32'h1000);
        check("f1_busy", busy_o, 1'b1);
        check("f1_ready", pix_ready_o, 1'b1);
        run_to_done("f1_done");
        check_frame("f1", 32'h1000);
        check("f1_consecutive", wr_cyc[11] - wr_cyc[0], 11);
        check("f1_done_lat", cyc - wr_cyc[11], 1);
        check("f1_busy_end", busy_o, 1'b0);
        check("f1_ready_end", pix_ready_o, 1'b0);

        // Stall the second write for three cycles.
        start_frame(32'h1000);
        tick();
        tick();
        avm_waitrequest_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d_write", i), avm_write_o, 1'b1);
            check($sformatf("stall%0d_addr", i), avm_address_o, 32'h1001);
            check($sformatf("stall%0d_data", i), avm_writedata_o, 8'h41);
            check($sformatf("stall%0d_ready", i), pix_ready_o, 1'b0);
            tick();
        end
        avm_waitrequest_i = 1'b0;
        run_to_done("f2_done");
        check_frame("f2", 32'h1000);

        // Valid toggling every cycle.
        start_frame(32'h1000);
        for (int i = 0; i < 100 && !done_o; i++) begin
            pix_valid_i = (i % 2 == 0);
            tick();
        end
        check("f3_done", done_o, 1'b1);
        pix_valid_i = 1'b1;
        check_frame("f3", 32'h1000);
        check("f3_gap", wr_cyc[1] - wr_cyc[0], 2);
        check("f3_xy0", {acc_x[0], acc_y[0]}, {2'd0, 2'd0});
        check("f3_xy1", {acc_x[1], acc_y[1]}, {2'd1, 2'd0});
        check("f3_xy2", {acc_x[2], acc_y[2]}, {2'd2, 2'd0});
        check("f3_xy3", {acc_x[3], acc_y[3]}, {2'd3, 2'd0});
        check("f3_xy4", {acc_x[4], acc_y[4]}, {2'd0, 2'd1});

        // Start during RUN is ignored; start in DONE launches a new frame.
        start_frame(32'h1000);
        tick();
        tick();
        tick();
        base_addr_i = 32'h2000;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
        check("f4_busy_after_start", busy_o, 1'b1);
        run_to_done("f4_done");
        check_frame("f4", 32'h1000);
        start_frame(32'h2000);
        check("f5_busy", busy_o, 1'b1);
        run_to_done("f5_done");
        check_frame("f5", 32'h2000);

        // Reset mid-frame with a stalled write pending.
        start_frame(32'h1000);
        for (int i = 0; i < 30 && acc_x.size() < 5; i++) tick();
        check("f6_acc5", acc_x.size(), 5);
        check("f6_write_pending", avm_write_o, 1'b1);
        avm_waitrequest_i = 1'b1;
        rst_n_i           = 1'b0;
        start_i           = 1'b1;
        tick();
        rst_n_i           = 1'b0;
        start_i           = 1'b0;
        rst_n_i           = 1'b1;
        #1;
        check("f6_busy", busy_o, 1'b0);
        check("f6_done", done_o, 1'b0);
        check("f6_write", avm_write_o, 1'b0);
        check("f6_x", X_o, 2'd0);
        check("f6_y", Y_o, 2'd0);
        check("f6_ready", pix_ready_o, 1'b0);
        avm_waitrequest_i = 1'b0;

        // Address wrap at the top of the address space.
        start_frame(32'hFFFF_FFFE);
        run_to_done("f7_done");
        check("f7_addr0", wr_addr[0], 32'hFFFF_FFFE);
        check("f7_addr1", wr_addr[1], 32'hFFFF_FFFF);
        check("f7_addr2", wr_addr[2], 32'h0000_0000);
        check("f7_addr11", wr_addr[11], 32'h0000_0009);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
